// File: rtl/aexm_memu_if.sv
// Data-cache bus between the memory-access stage and the data cache.
// The memory stage is the master. The cache answers with dc_ack and dc_rdat.
interface aexm_memu_if #(
  parameter int DW = 32
);
  logic          dc_req;
  logic          dc_we;
  logic [DW-3:0] dc_addr;
  logic [3:0]    dc_sel;
  logic [31:0]   dc_wdat;
  logic          dc_ack;
  logic [31:0]   dc_rdat;

  modport master (
    output dc_req, dc_we, dc_addr, dc_sel, dc_wdat,
    input  dc_ack, dc_rdat
  );

  modport slave (
    input  dc_req, dc_we, dc_addr, dc_sel, dc_wdat,
    output dc_ack, dc_rdat
  );
endinterface

// File: rtl/aexm_memu.sv
// Memory-access stage. It runs one data-cache transaction per load/store
// coming out of execute, and stalls the pipeline until the cache acks or the
// access times out. It returns load data lane-aligned and zero-extended on
// rDWBDI, which execute uses as a forwarding source.
module aexm_memu #(
  parameter int DW  = 32,
  parameter int TMO = 255
) (
  input  logic        gclk,
  input  logic        grst,
  input  logic        rMEM_VLD,
  input  logic [5:0]  rOPC,
  input  logic [31:0] rRESULT,
  input  logic [3:0]  rDWBSEL,
  input  logic [31:0] rREGD,
  aexm_memu_if.master dbus,
  output logic        mSTALL,
  output logic [31:0] rDWBDI,
  output logic        rBUSERR
);

  // Last REQ-state count value before the access is abandoned.
  localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } stateT;

  stateT         stateReg, stateNext;
  logic          dcReqReg, dcReqNext;
  logic          dcWeReg, dcWeNext;
  logic [DW-3:0] dcAddrReg, dcAddrNext;
  logic [3:0]    dcSelReg, dcSelNext;
  logic [31:0]   dcWdatReg, dcWdatNext;
  logic [31:0]   dwbdiReg, dwbdiNext;
  logic          busErrReg, busErrNext;
  logic [7:0]    cntReg, cntNext;

  // Opcode bits above [2] and the byte offset of the address do not matter here.
  logic unusedBits;
  assign unusedBits = ^{rOPC[5:3], rRESULT[1:0]};

  // Pick the addressed lane(s) out of the big-endian read word and zero-extend them.
  function automatic logic [31:0] alignLoad(input logic [3:0] sel, input logic [31:0] d);
    logic [31:0] r;
    case (sel)
      4'h8:    r = {24'd0, d[31:24]};
      4'h4:    r = {24'd0, d[23:16]};
      4'h2:    r = {24'd0, d[15:8]};
      4'h1:    r = {24'd0, d[7:0]};
      4'hC:    r = {16'd0, d[31:16]};
      4'h3:    r = {16'd0, d[15:0]};
      4'hF:    r = d;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Replicate the store operand across all lanes so that dc_sel alone picks the bytes.
  function automatic logic [31:0] replStore(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] r;
    case (sz)
      2'd0:    r = {4{d[7:0]}};
      2'd1:    r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  // Next-state and next-register logic. Every register holds unless a transition updates it.
  always_comb begin
    stateNext  = stateReg;
    dcReqNext  = dcReqReg;
    dcWeNext   = dcWeReg;
    dcAddrNext = dcAddrReg;
    dcSelNext  = dcSelReg;
    dcWdatNext = dcWdatReg;
    dwbdiNext  = dwbdiReg;
    busErrNext = busErrReg;
    cntNext    = cntReg;
    case (stateReg)
      IDLE: begin
        if (rMEM_VLD) begin
          busErrNext = 1'b0;
          if (rOPC[1:0] == 2'd3) begin
            // FSL accesses never touch the cache. They only take the DONE slot.
            stateNext = DONE;
            dwbdiNext = 32'd0;
          end else begin
            stateNext  = REQ;
            dcReqNext  = 1'b1;
            dcWeNext   = rOPC[2];
            dcAddrNext = rRESULT[DW-1:2];
            dcSelNext  = rDWBSEL;
            dcWdatNext = replStore(rOPC[1:0], rREGD);
            cntNext    = 8'd0;
          end
        end
      end
      REQ: begin
        if (dbus.dc_ack) begin
          // An ack in the last allowed cycle still counts as a normal completion.
          stateNext  = DONE;
          dcReqNext  = 1'b0;
          dcWeNext   = 1'b0;
          busErrNext = 1'b0;
          if (!dcWeReg) dwbdiNext = alignLoad(dcSelReg, dbus.dc_rdat);
        end else if (cntReg == TMO_LAST) begin
          stateNext  = DONE;
          dcReqNext  = 1'b0;
          dcWeNext   = 1'b0;
          busErrNext = 1'b1;
          if (!dcWeReg) dwbdiNext = 32'd0;
        end else begin
          cntNext = cntReg + 8'd1;
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // State and output registers. Reset clears everything, including a request in flight.
  always_ff @(posedge gclk or negedge grst) begin
    if (!grst) begin
      stateReg  <= IDLE;
      dcReqReg  <= 1'b0;
      dcWeReg   <= 1'b0;
      dcAddrReg <= '0;
      dcSelReg  <= 4'd0;
      dcWdatReg <= 32'd0;
      dwbdiReg  <= 32'd0;
      busErrReg <= 1'b0;
      cntReg    <= 8'd0;
    end else begin
      stateReg  <= stateNext;
      dcReqReg  <= dcReqNext;
      dcWeReg   <= dcWeNext;
      dcAddrReg <= dcAddrNext;
      dcSelReg  <= dcSelNext;
      dcWdatReg <= dcWdatNext;
      dwbdiReg  <= dwbdiNext;
      busErrReg <= busErrNext;
      cntReg    <= cntNext;
    end
  end

  // Stall while accepting and while waiting on the cache. Nothing is accepted during reset.
  always_comb begin
    mSTALL = grst & (((stateReg == IDLE) & rMEM_VLD) | (stateReg == REQ));
  end

  assign dbus.dc_req  = dcReqReg;
  assign dbus.dc_we   = dcWeReg;
  assign dbus.dc_addr = dcAddrReg;
  assign dbus.dc_sel  = dcSelReg;
  assign dbus.dc_wdat = dcWdatReg;
  assign rDWBDI       = dwbdiReg;
  assign rBUSERR      = busErrReg;

endmodule
